// File: rtl/sumapf_pkg.sv
// Shared types and constants for the multi-cycle single-precision add/subtract sequencer.
package sumapf_pkg;

   localparam int EXP_W  = 8;
   localparam int MAN_W  = 23;
   localparam int MANT_W = MAN_W + 1;
   localparam int SUM_W  = MANT_W + 1;
   localparam int WORD_W = 1 + EXP_W + MAN_W;

   localparam logic [WORD_W-1:0] QNAN    = 32'h7FC00000;
   localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;

   typedef enum logic [2:0] {IDLE, COMPARE, ALIGN, ADD, NORM, DONE} state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } fp_unp_t;

   // Denormals flush to zero: a zero exponent carries no hidden bit and no fraction.
   function automatic fp_unp_t fp_unpack(input logic [WORD_W-1:0] w);
      fp_unp_t u;
      u.sign = w[WORD_W-1];
      u.exp  = w[WORD_W-2:MAN_W];
      u.mant = (u.exp == '0) ? '0 : {1'b1, w[MAN_W-1:0]};
      return u;
   endfunction

endpackage

// File: rtl/sumapf_seq_ctrl_if.sv
// Operand/result bus of the FP add/subtract sequencer, plus its FSM state for observation.
interface sumapf_seq_ctrl_if;
   import sumapf_pkg::*;

   // valid/ready: a transfer happens on a rising edge where both are high; the producer
   // holds valid and its payload steady until that edge, and ready never depends on valid.
   logic               in_valid;
   logic               in_ready;
   logic [WORD_W-1:0]  a;
   logic [WORD_W-1:0]  b;
   logic               op_sub;
   logic               out_valid;
   logic               out_ready;
   logic [WORD_W-1:0]  result;
   logic               ovf;
   logic               busy;
   state_t             dbg_state;

   modport master (
      output in_valid, a, b, op_sub, out_ready,
      input  in_ready, out_valid, result, ovf, busy, dbg_state
   );

   modport slave (
      input  in_valid, a, b, op_sub, out_ready,
      output in_ready, out_valid, result, ovf, busy, dbg_state
   );

endinterface

// File: rtl/sumapf_seq_ctrl_restador.sv
// N-bit unsigned subtractor used for the exponent difference (minuend is never the smaller).
module restadorNbits #(
   parameter int N = 8
) (
   input  logic [N-1:0] i_minuend,
   input  logic [N-1:0] i_subtrahend,
   output logic [N-1:0] o_diff
);

   assign o_diff = i_minuend - i_subtrahend;

endmodule

// File: rtl/sumapf_seq_ctrl.sv
// Bit-serial IEEE-754 single add/subtract: compare, align one bit per cycle, add,
// normalize one bit per cycle, then hold the truncated result until it is taken.
module sumapf_seq_ctrl
   import sumapf_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   sumapf_seq_ctrl_if.slave bus
);

   state_t              r_state;
   logic [WORD_W-1:0]   r_a;
   logic [WORD_W-1:0]   r_b;
   logic                r_big_sign;
   logic                r_sign_diff;
   logic [EXP_W-1:0]    r_exp;
   logic [MANT_W-1:0]   r_big_mant;
   logic [MANT_W-1:0]   r_small_mant;
   logic [EXP_W-1:0]    r_d;
   logic [SUM_W-1:0]    r_sum;
   logic [WORD_W-1:0]   r_result;
   logic                r_ovf;
   logic                r_out_valid;
   logic                r_in_ready;
   logic                r_busy;
   logic                r_special_wait;

   fp_unp_t             w_ua;
   fp_unp_t             w_ub;
   fp_unp_t             w_big;
   fp_unp_t             w_small;
   logic                w_swap;
   logic                w_a_inf;
   logic                w_b_inf;
   logic                w_a_nan;
   logic                w_b_nan;
   logic [EXP_W-1:0]    w_diff;

   assign w_ua    = fp_unpack(r_a);
   assign w_ub    = fp_unpack(r_b);
   assign w_swap  = {w_ub.exp, w_ub.mant} > {w_ua.exp, w_ua.mant};
   assign w_big   = w_swap ? w_ub : w_ua;
   assign w_small = w_swap ? w_ua : w_ub;
   assign w_a_inf = (w_ua.exp == EXP_MAX) && (r_a[MAN_W-1:0] == '0);
   assign w_b_inf = (w_ub.exp == EXP_MAX) && (r_b[MAN_W-1:0] == '0);
   assign w_a_nan = (w_ua.exp == EXP_MAX) && (r_a[MAN_W-1:0] != '0);
   assign w_b_nan = (w_ub.exp == EXP_MAX) && (r_b[MAN_W-1:0] != '0);

   restadorNbits #(.N(EXP_W)) u_exp_diff (
      .i_minuend    (w_big.exp),
      .i_subtrahend (w_small.exp),
      .o_diff       (w_diff)
   );

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.ovf       = r_ovf;
   assign bus.busy      = r_busy;
   assign bus.dbg_state = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_a            <= '0;
         r_b            <= '0;
         r_big_sign     <= 1'b0;
         r_sign_diff    <= 1'b0;
         r_exp          <= '0;
         r_big_mant     <= '0;
         r_small_mant   <= '0;
         r_d            <= '0;
         r_sum          <= '0;
         r_result       <= '0;
         r_ovf          <= 1'b0;
         r_out_valid    <= 1'b0;
         r_in_ready     <= 1'b1;
         r_busy         <= 1'b0;
         r_special_wait <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_a        <= bus.a;
                  r_b        <= {bus.b[WORD_W-1] ^ bus.op_sub, bus.b[WORD_W-2:0]};
                  r_ovf      <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= COMPARE;
               end
            end
            COMPARE: begin
               // Special results settle one cycle in DONE before being presented.
               if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_ua.sign != w_ub.sign))) begin
                  r_result       <= QNAN;
                  r_special_wait <= 1'b1;
                  r_state        <= DONE;
               end else if (w_a_inf || w_b_inf) begin
                  r_result       <= w_a_inf ? r_a : r_b;
                  r_special_wait <= 1'b1;
                  r_state        <= DONE;
               end else begin
                  r_big_sign  <= w_big.sign;
                  r_sign_diff <= w_ua.sign ^ w_ub.sign;
                  r_exp       <= w_big.exp;
                  r_big_mant  <= w_big.mant;
                  if (w_diff > 8'd24) begin
                     r_small_mant <= '0;
                     r_d          <= '0;
                     r_state      <= ADD;
                  end else begin
                     r_small_mant <= w_small.mant;
                     r_d          <= w_diff;
                     r_state      <= (w_diff != '0) ? ALIGN : ADD;
                  end
               end
            end
            ALIGN: begin
               r_small_mant <= r_small_mant >> 1;
               r_d          <= r_d - 8'd1;
               if (r_d == 8'd1) r_state <= ADD;
            end
            ADD: begin
               r_sum   <= r_sign_diff ? ({1'b0, r_big_mant} - {1'b0, r_small_mant})
                                      : ({1'b0, r_big_mant} + {1'b0, r_small_mant});
               r_state <= NORM;
            end
            NORM: begin
               if (r_sum == '0) begin
                  r_result    <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else if (r_sum[SUM_W-1]) begin
                  if (r_exp == EXP_MAX - 8'd1) begin
                     r_result <= {r_big_sign, EXP_MAX, {MAN_W{1'b0}}};
                     r_ovf    <= 1'b1;
                  end else begin
                     r_result <= {r_big_sign, r_exp + 8'd1, r_sum[MAN_W:1]};
                  end
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else if (r_sum[MAN_W]) begin
                  r_result    <= {r_big_sign, r_exp, r_sum[MAN_W-1:0]};
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else if (r_exp == 8'd1) begin
                  r_result    <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_sum <= r_sum << 1;
                  r_exp <= r_exp - 8'd1;
               end
            end
            DONE: begin
               if (r_special_wait) begin
                  r_special_wait <= 1'b0;
                  r_out_valid    <= 1'b1;
               end else if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sumapf_seq_ctrl.sv
// Directed and randomized check of the FP add/subtract sequencer against an arithmetic reference.
module tb_sumapf_seq_ctrl;
   import sumapf_pkg::*;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;
   logic [31:0] exp_q[$];

   sumapf_seq_ctrl_if bus ();

   sumapf_seq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: IEEE single add with flush-to-zero, truncation and the sequencer's cycle cost.
   task automatic ref_model(input logic [31:0] a, input logic [31:0] b_in, input logic sub,
                            output logic [31:0] res, output logic ovf, output int d, output int lat);
      logic [31:0] b;
      int ea, eb, ma, mb, ebig, esml, mbig, msml, s, e, k;
      logic sa, sb, sbig, a_big, fin;
      b = b_in;
      b[31] = b_in[31] ^ sub;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      sa = a[31];
      sb = b[31];
      ovf = 1'b0;
      d = 0;
      lat = 2;
      res = 32'h0;
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) res = 32'h7FC00000;
      else if (ea == 255 && eb == 255) res = (sa == sb) ? a : 32'h7FC00000;
      else if (ea == 255) res = a;
      else if (eb == 255) res = b;
      else begin
         ma = (ea == 0) ? 0 : (1 << 23) + int'(a[22:0]);
         mb = (eb == 0) ? 0 : (1 << 23) + int'(b[22:0]);
         a_big = !((eb > ea) || (eb == ea && mb > ma));
         ebig = a_big ? ea : eb;
         esml = a_big ? eb : ea;
         mbig = a_big ? ma : mb;
         msml = a_big ? mb : ma;
         sbig = a_big ? sa : sb;
         d = ebig - esml;
         if (d > 24) begin
            msml = 0;
            d = 0;
         end else msml = msml >> d;
         s = (sa == sb) ? mbig + msml : mbig - msml;
         e = ebig;
         k = 0;
         fin = 1'b0;
         while (!fin) begin
            if (s == 0) begin
               res = 32'h0;
               fin = 1'b1;
            end else if (s >= (1 << 24)) begin
               e++;
               if (e == 255) begin
                  res = {sbig, 8'hFF, 23'h0};
                  ovf = 1'b1;
               end else res = {sbig, 8'(e), 23'(s >> 1)};
               fin = 1'b1;
            end else if (s >= (1 << 23)) begin
               res = {sbig, 8'(e), 23'(s)};
               fin = 1'b1;
            end else if (e == 1) begin
               res = 32'h0;
               fin = 1'b1;
            end else begin
               s = s * 2;
               e--;
               k++;
            end
         end
         lat = 3 + d + k;
      end
   endtask

   // driver: issue one pair and wait for the result; leaves the block holding it in DONE
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input string tag);
      logic [31:0] er;
      logic eo;
      int ed, el, cyc, aligns, waitc;
      ref_model(a, b, sub, er, eo, ed, el);
      exp_q.push_back(er);
      waitc = 0;
      while (!bus.in_ready && waitc < 100) begin
         @(posedge clk); #1;
         waitc++;
      end
      chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.a = a;
      bus.b = b;
      bus.op_sub = sub;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      cyc = 0;
      aligns = 0;
      while (!bus.out_valid && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.dbg_state == ALIGN) aligns++;
      end
      chk({tag, ".result"}, bus.result, exp_q.pop_front());
      chk({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
      chk({tag, ".latency"}, 32'(cyc), 32'(el));
      chk({tag, ".align_cycles"}, 32'(aligns), 32'(ed));
   endtask

   task automatic release_result(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, ".rel_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".rel_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, ".rel_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      int ea, eb;
      compared = 0;
      mismatched = 0;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.op_sub = 1'b0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      #12;
      chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset.result", bus.result, 32'h0);
      chk("reset.ovf", 32'(bus.ovf), 32'd0);
      chk("reset.busy", 32'(bus.busy), 32'd0);
      chk("reset.state", 32'(bus.dbg_state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed cases with hand-derived values
      do_op(32'h3F800000, 32'h3F800000, 1'b0, "one_plus_one");
      chk("one_plus_one.const", bus.result, 32'h40000000);
      chk("one_plus_one.busy", 32'(bus.busy), 32'd1);
      release_result("one_plus_one");
      do_op(32'h3F800000, 32'h3F000000, 1'b0, "one_plus_half");
      chk("one_plus_half.const", bus.result, 32'h3FC00000);
      release_result("one_plus_half");
      do_op(32'h3FC00000, 32'h3FA00000, 1'b1, "sub_norm2");
      chk("sub_norm2.const", bus.result, 32'h3E800000);
      release_result("sub_norm2");
      do_op(32'h3F800000, 32'h3F800000, 1'b1, "cancel");
      chk("cancel.const", bus.result, 32'h00000000);
      release_result("cancel");
      do_op(32'h7F800000, 32'h7F800000, 1'b1, "inf_minus_inf");
      chk("inf_minus_inf.const", bus.result, 32'h7FC00000);
      release_result("inf_minus_inf");

      // overflow result held under backpressure while input pulses are ignored
      do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, "overflow");
      chk("overflow.const", bus.result, 32'h7F800000);
      chk("overflow.ovf_const", 32'(bus.ovf), 32'd1);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.a = $urandom;
         bus.b = $urandom;
         @(posedge clk); #1;
         chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp.result", bus.result, 32'h7F800000);
         chk("bp.ovf", 32'(bus.ovf), 32'd1);
         chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      release_result("bp");
      do_op(32'h3F800000, 32'h3F800000, 1'b0, "after_bp");
      chk("after_bp.ovf_cleared", 32'(bus.ovf), 32'd0);
      release_result("after_bp");

      // asynchronous reset in the middle of a 24-step alignment
      bus.a = 32'h4B800000;
      bus.b = 32'h3F800000;
      bus.op_sub = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      chk("midrst.in_align", 32'(bus.dbg_state), 32'(ALIGN));
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst.in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst.busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(32'h3F800000, 32'h3F800000, 1'b0, "post_rst");
      chk("post_rst.const", bus.result, 32'h40000000);
      release_result("post_rst");

      // randomized operands clustered so alignment, cancellation and specials all occur
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 15))
            0:       ea = 255;
            1:       ea = 0;
            default: ea = int'($urandom_range(1, 254));
         endcase
         eb = ea + int'($urandom_range(0, 60)) - 30;
         if (eb < 0) eb = 0;
         if (eb > 255) eb = 255;
         ra = {1'($urandom), 8'(ea), 23'($urandom)};
         rb = {1'($urandom), 8'(eb), 23'($urandom)};
         if ($urandom_range(0, 3) == 0) rb = {rb[31], ra[30:8], rb[7:0]};
         if ($urandom_range(0, 7) == 0) rb[22:0] = 23'h0;
         do_op(ra, rb, 1'($urandom), "rand");
         if ($urandom_range(0, 1) == 1) begin
            for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
               @(posedge clk); #1;
            end
         end
         release_result("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
